note_tone_generator: RTL and testbench
======================================

Name: note_tone_generator

Overview:
Downstream consumer of the note-duration gate (play_sound) from the duration divider. It latches a note code and an octave on each gate rising edge. While the gate is high it drives a 50%-duty square wave on the speaker pin at the note's pitch. When the gate falls it finishes the current high half-cycle cleanly, then reports completion to the sequencer.

Parameters:
HALF_W, 18, width of the half-period counter and table entries (max entry 191113 < 2^18)
CLK_HZ, 100000000, documentation only; the pitch table below is fixed for this clock

Ports:
clk  input  1  system clock, 100 MHz
rst  input  1  synchronous, active-high reset
play_sound  input  1  note gate from the duration divider; high = sound the note
note_code  input  4  0 = rest, 1..13 = C4..C5 chromatic, 14..15 = rest
octave  input  2  right-shift applied to the half-period (0 = base octave, 3 = +3 octaves)
speaker  output  1  square-wave audio output
amp_en  output  1  high while a pitched note is sounding (PLAY or STOP)
busy  output  1  high in any state other than IDLE
note_done  output  1  one-cycle pulse when a note or rest completes

Behaviour:
- Reset: state=IDLE; speaker=0; amp_en=0; busy=0; note_done=0; counter=0; pend=0; gate_q=1. Because gate_q resets to 1, a gate held high through reset does not start a note; a fresh rising edge is required.
- gate_q <= play_sound every cycle. rise = play_sound & ~gate_q. fall = ~play_sound & gate_q.
- Pitch table (half-period in cycles), codes 1..13: 191113, 180388, 170262, 160706, 151686, 143173, 135139, 127551, 120395, 113636, 107259, 101238, 95557.
- On rise, latch half = table[note_code] >> octave, and latch rest = (note_code == 0 or note_code >= 14).
- Later changes on note_code or octave are ignored until the next rise.
- IDLE: on rise, the same edge goes to REST (if rest) or PLAY; otherwise stay in IDLE.
- PLAY entry: speaker=1, counter=0, amp_en=1, busy=1.
- PLAY: counter increments each cycle. When counter == half-1, toggle speaker and clear counter, so each half-cycle is exactly `half` clocks. On fall, go to STOP.
- STOP: counting and toggling continue.
  - At the first cycle where speaker would toggle from 1 to 0, or immediately if speaker is already 0 at STOP entry: speaker=0, amp_en=0, note_done=1 for one cycle.
  - Then go to IDLE, or straight into PLAY/REST if pend=1.
- REST: speaker=0, amp_en=0, busy=1. On fall, pulse note_done and go to IDLE (or the pending note).
- pend: a rise that occurs during STOP sets pend and latches that rise's code/octave into the next-note registers. pend is cleared when the pending note starts.
- Only STOP can see a rise; PLAY and REST exit only on fall.
- Latency: rise at sampled edge k → speaker=1 at edge k. Fall at edge k → STOP at edge k. note_done ≤ half+1 cycles later.
- Zero-length gate (rise then fall next cycle): still produces one full high half-cycle before note_done.
- Reset mid-note: immediate return to the reset values; no note_done is issued.

Test Plan:
- Reset, then gate high with code 10, octave 0 → speaker rises the cycle after the rise is seen; toggles every 113636 cycles (period 227272); amp_en=1, busy=1.
- Code 10, octave 1 → half-period 56818; code 1, octave 3 → 191113>>3 = 23889.
- Gate falls 1000 cycles into a high half → speaker stays high until cycle 113636 of that half, then goes 0; single note_done pulse; IDLE; busy=0.
- Code 0 and code 15 → speaker stays 0, amp_en=0, busy=1; note_done on fall.
- Rise arrives during STOP with code 13 → after note_done, PLAY begins at once with half 95557 and no IDLE cycle; changing note_code mid-note has no effect.
- Gate held high across reset release → no note starts; rst asserted mid-PLAY → all outputs 0 next cycle and no note_done.

Source files
------------

// File: rtl/note_tone_generator.sv
// Note tone generator: latches a note on each gate rising edge, drives a 50%-duty
// square wave while the gate is high, and ends on a clean high-to-low edge.
module note_tone_generator #(
  parameter int unsigned HALF_W = 18,
  parameter int unsigned CLK_HZ = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       play_sound,
  input  logic [3:0] note_code,
  input  logic [1:0] octave,
  output logic       speaker,
  output logic       amp_en,
  output logic       busy,
  output logic       note_done
);

  // The pitch table holds cycle counts for a 100 MHz clock only.
  if (CLK_HZ != 32'd100000000) begin : g_clk_check
    $error("note_tone_generator: pitch table assumes a 100 MHz clock");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    STOP = 2'd2,
    REST = 2'd3
  } state_e;

  function automatic logic [HALF_W-1:0] pitch_half(input logic [3:0] code);
    logic [HALF_W-1:0] h;
    case (code)
      4'd1:    h = HALF_W'(191113);
      4'd2:    h = HALF_W'(180388);
      4'd3:    h = HALF_W'(170262);
      4'd4:    h = HALF_W'(160706);
      4'd5:    h = HALF_W'(151686);
      4'd6:    h = HALF_W'(143173);
      4'd7:    h = HALF_W'(135139);
      4'd8:    h = HALF_W'(127551);
      4'd9:    h = HALF_W'(120395);
      4'd10:   h = HALF_W'(113636);
      4'd11:   h = HALF_W'(107259);
      4'd12:   h = HALF_W'(101238);
      4'd13:   h = HALF_W'(95557);
      default: h = HALF_W'(1);
    endcase
    return h;
  endfunction

  state_e            state_q, state_d;
  logic [HALF_W-1:0] cnt_q, cnt_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic [HALF_W-1:0] nhalf_q, nhalf_d;
  logic              rest_q, rest_d;
  logic              nrest_q, nrest_d;
  logic              pend_q, pend_d;
  logic              speaker_q, speaker_d;
  logic              amp_en_q, amp_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              gate_q;

  logic              rise_c;
  logic              finish_c;
  logic [HALF_W-1:0] half_lk_c;
  logic              rest_lk_c;
  logic              half_end_c;

  assign rise_c     = play_sound & ~gate_q;
  assign rest_lk_c  = (note_code == 4'd0) || (note_code >= 4'd14);
  assign half_lk_c  = pitch_half(note_code) >> octave;
  assign half_end_c = (cnt_q == half_q - HALF_W'(1));

  // Next-state and output logic; a finishing note may chain straight into the next one.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    half_d    = half_q;
    rest_d    = rest_q;
    nhalf_d   = nhalf_q;
    nrest_d   = nrest_q;
    pend_d    = pend_q;
    speaker_d = speaker_q;
    done_d    = 1'b0;
    finish_c  = 1'b0;

    case (state_q)
      IDLE: begin
        if (rise_c) begin
          state_d   = rest_lk_c ? REST : PLAY;
          half_d    = half_lk_c;
          rest_d    = rest_lk_c;
          speaker_d = ~rest_lk_c;
          cnt_d     = '0;
        end
      end
      PLAY: begin
        if (half_end_c) begin
          speaker_d = ~speaker_q;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + HALF_W'(1);
        end
        if (!play_sound) state_d = STOP;
      end
      STOP: begin
        if (!speaker_q || half_end_c) begin
          finish_c = 1'b1;
        end else begin
          cnt_d = cnt_q + HALF_W'(1);
          if (rise_c) begin
            pend_d  = 1'b1;
            nhalf_d = half_lk_c;
            nrest_d = rest_lk_c;
          end
        end
      end
      REST: begin
        if (!play_sound) finish_c = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (finish_c) begin
      done_d    = 1'b1;
      speaker_d = 1'b0;
      cnt_d     = '0;
      state_d   = IDLE;
      if (rise_c) begin
        state_d   = rest_lk_c ? REST : PLAY;
        half_d    = half_lk_c;
        rest_d    = rest_lk_c;
        speaker_d = ~rest_lk_c;
      end else if (pend_q) begin
        state_d   = nrest_q ? REST : PLAY;
        half_d    = nhalf_q;
        rest_d    = nrest_q;
        speaker_d = ~nrest_q;
        pend_d    = 1'b0;
      end
    end

    amp_en_d = (state_d == PLAY) || (state_d == STOP);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      half_q    <= '0;
      rest_q    <= 1'b0;
      nhalf_q   <= '0;
      nrest_q   <= 1'b0;
      pend_q    <= 1'b0;
      speaker_q <= 1'b0;
      amp_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      gate_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      half_q    <= half_d;
      rest_q    <= rest_d;
      nhalf_q   <= nhalf_d;
      nrest_q   <= nrest_d;
      pend_q    <= pend_d;
      speaker_q <= speaker_d;
      amp_en_q  <= amp_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      gate_q    <= play_sound;
    end
  end

  assign speaker   = speaker_q;
  assign amp_en    = amp_en_q;
  assign busy      = busy_q;
  assign note_done = done_q;

endmodule

// File: tb/tb_note_tone_generator.sv
// Bench for note_tone_generator: randomized notes, rests, chained notes and resets,
// checked every cycle against a timeline model built from note start/fall times.
module tb_note_tone_generator;

  logic       clk = 1'b0;
  logic       rst;
  logic       play_sound;
  logic [3:0] note_code;
  logic [1:0] octave;
  logic       speaker;
  logic       amp_en;
  logic       busy;
  logic       note_done;

  always #5 clk = ~clk;

  note_tone_generator dut (
    .clk       (clk),
    .rst       (rst),
    .play_sound(play_sound),
    .note_code (note_code),
    .octave    (octave),
    .speaker   (speaker),
    .amp_en    (amp_en),
    .busy      (busy),
    .note_done (note_done)
  );

  localparam int PITCH [14] = '{0, 191113, 180388, 170262, 160706, 151686, 143173,
                                135139, 127551, 120395, 113636, 107259, 101238, 95557};

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int          cyc      = 0;
  string       phase    = "init";

  // Each note: start edge, done edge, half-period, rest flag.
  int ns[$];
  int nd[$];
  int nh[$];
  bit nr[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Expected {speaker, amp_en, busy, note_done} after edge e.
  function automatic logic [3:0] model_outs(input int e);
    logic [3:0] o;
    o = 4'b0;
    foreach (ns[i]) begin
      if (e >= ns[i] && e < nd[i]) begin
        o[1] = 1'b1;
        if (!nr[i]) begin
          o[2] = 1'b1;
          if (((e - ns[i]) / nh[i]) % 2 == 0) o[3] = 1'b1;
        end
      end
      if (e == nd[i]) o[0] = 1'b1;
    end
    return o;
  endfunction

  // Done edge: first edge after the fall where the wave is already low or drops high->low.
  function automatic int done_edge(input int s, input int f, input int h, input bit r);
    if (r) return f;
    for (int e = f + 1; e < f + 3 * h + 4; e++) begin
      if (((e - 1 - s) / h) % 2 == 1) return e;
      if ((e - s) % h == 0 && ((e - s) / h) % 2 == 1) return e;
    end
    return -1;
  endfunction

  function automatic int half_of(input logic [3:0] code, input logic [1:0] oct);
    if (code == 4'd0 || code >= 4'd14) return 1;
    return PITCH[int'(code)] >> oct;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rst) check_eq({phase, "_rst"}, 32'({speaker, amp_en, busy, note_done}), 32'(0));
    else     check_eq(phase, 32'({speaker, amp_en, busy, note_done}), 32'(model_outs(cyc)));
  endtask

  task automatic add_note(input int s, input int d, input int h, input bit r);
    ns.push_back(s);
    nd.push_back(d);
    nh.push_back(h);
    nr.push_back(r);
  endtask

  // Gate high for len cycles starting at the next edge; note inputs scrambled after the rise.
  task automatic play_note(input logic [3:0] code, input logic [1:0] oct, input int len);
    int s, f, h, d;
    bit r;
    r = (code == 4'd0) || (code >= 4'd14);
    h = half_of(code, oct);
    s = cyc + 1;
    f = s + len;
    d = done_edge(s, f, h, r);
    add_note(s, d, h, r);
    play_sound = 1'b1;
    note_code  = code;
    octave     = oct;
    while (cyc < f - 1) begin
      tick();
      note_code = 4'($urandom);
      octave    = 2'($urandom);
    end
    play_sound = 1'b0;
    while (cyc < d + 3) tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int s, fa, da, sb, fb, db, r, h, len, mode;
    logic [3:0] code;

    rst        = 1'b1;
    play_sound = 1'b1;
    note_code  = 4'd10;
    octave     = 2'd0;
    phase      = "reset";
    repeat (5) tick();

    rst   = 1'b0;
    phase = "held_gate";
    repeat (20) tick();
    play_sound = 1'b0;
    repeat (3) tick();

    phase = "rand_note";
    for (int i = 0; i < 3; i++) begin
      code = 4'(11 + $urandom_range(0, 2));
      h    = half_of(code, 2'd3);
      mode = i;
      if (mode == 0)      len = 1;
      else if (mode == 1) len = int'($urandom_range(2, 400));
      else                len = h + int'($urandom_range(0, 400));
      play_note(code, 2'd3, len);
    end

    phase = "rest";
    play_note(4'd0,  2'($urandom), int'($urandom_range(1, 40)));
    play_note(4'd15, 2'($urandom), int'($urandom_range(1, 40)));
    play_note(4'd14, 2'($urandom), 1);

    // Rise during STOP chains a second note with no idle gap.
    phase = "pend";
    s  = cyc + 1;
    h  = half_of(4'd12, 2'd3);
    fa = s + 1000;
    da = done_edge(s, fa, h, 1'b0);
    add_note(s, da, h, 1'b0);
    play_sound = 1'b1;
    note_code  = 4'd12;
    octave     = 2'd3;
    while (cyc < fa - 1) begin
      tick();
      note_code = 4'($urandom);
    end
    play_sound = 1'b0;
    r = fa + 5;
    while (cyc < r - 1) tick();
    sb = da;
    h  = half_of(4'd13, 2'd3);
    fb = sb + 1 + int'($urandom_range(0, 300));
    db = done_edge(sb, fb, h, 1'b0);
    add_note(sb, db, h, 1'b0);
    play_sound = 1'b1;
    note_code  = 4'd13;
    octave     = 2'd3;
    while (cyc < fb - 1) begin
      tick();
      note_code = 4'($urandom);
      octave    = 2'($urandom);
    end
    play_sound = 1'b0;
    while (cyc < db + 3) tick();

    // Reset mid-note: outputs clear, no completion, held gate does not restart.
    phase = "mid_rst";
    s = cyc + 1;
    add_note(s, 32'h7fffffff, half_of(4'd1, 2'd3), 1'b0);
    play_sound = 1'b1;
    note_code  = 4'd1;
    octave     = 2'd3;
    repeat (100) tick();
    rst = 1'b1;
    ns.delete();
    nd.delete();
    nh.delete();
    nr.delete();
    repeat (3) tick();
    rst   = 1'b0;
    phase = "post_rst";
    repeat (20) tick();
    play_sound = 1'b0;
    repeat (3) tick();
    play_note(4'd0, 2'd0, 5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
